// File: rtl/prim_assembler.sv
// Assembles a word stream into NUM_WORDS-word primitives delimited by start/end
// tokens. Completed primitives are pushed into a small FIFO with valid/ready output.
module prim_assembler #(
  parameter int                WORD_W      = 32,
  parameter int                NUM_WORDS   = 6,
  parameter int                OUT_DEPTH   = 2,
  parameter logic [WORD_W-1:0] START_TOKEN = '0,
  parameter logic [WORD_W-1:0] END_TOKEN   = WORD_W'(1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WORD_W*NUM_WORDS-1:0] prim_data,
  output logic                        prim_valid,
  input  logic                        prim_ready,
  output logic                        frame_active,
  output logic                        frame_done,
  output logic [15:0]                 drop_count
);

  localparam int PW    = WORD_W * NUM_WORDS;
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, END_CHK} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [PW-1:0]     asm_buf;
  logic [PW-1:0]     buf_nxt;
  logic [PW-1:0]     mem [OUT_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              last_idx;
  logic              accept;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == CNT_W'(OUT_DEPTH));
  assign last_idx     = (idx == IDX_W'(NUM_WORDS - 1));
  // The last word is held off whenever the queue is full, even if a pop is pending.
  assign in_ready     = !rst && !flush && !(state == COLLECT && last_idx && full);
  assign accept       = in_valid && in_ready;
  assign push         = accept && (state == COLLECT) && last_idx;
  assign prim_valid   = (count != '0);
  assign pop          = prim_valid && prim_ready && !flush;
  assign prim_data    = prim_valid ? mem[rd_ptr] : '0;
  assign frame_active = (state != IDLE);

  // idx is 0 in END_CHK, so the same merge places a restart word into slot 0.
  always_comb begin
    buf_nxt = asm_buf;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx == IDX_W'(k)) buf_nxt[k*WORD_W +: WORD_W] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= buf_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      asm_buf    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      frame_done <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      state      <= IDLE;
      idx        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (in_data == START_TOKEN) begin
              state <= COLLECT;
              idx   <= '0;
            end else if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
          end
          COLLECT: begin
            asm_buf <= buf_nxt;
            if (last_idx) begin
              state <= END_CHK;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          END_CHK: begin
            if (in_data == END_TOKEN) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end else begin
              asm_buf <= buf_nxt;
              state   <= COLLECT;
              idx     <= IDX_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            idx   <= '0;
          end
        endcase
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_prim_assembler.sv
// Bench for prim_assembler: directed frame scenarios plus random traffic, all
// checked every cycle against a word-list/primitive-queue reference model.
module tb_prim_assembler;
  localparam int WW = 32;
  localparam int NW = 6;
  localparam int OD = 2;
  localparam int PW = WW * NW;
  localparam logic [WW-1:0] STK = 32'd0;
  localparam logic [WW-1:0] ETK = 32'd1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, prim_valid, prim_ready;
  logic          frame_active, frame_done;
  logic [WW-1:0] in_data;
  logic [PW-1:0] prim_data;
  logic [15:0]   drop_count;

  prim_assembler #(.WORD_W(WW), .NUM_WORDS(NW), .OUT_DEPTH(OD),
                   .START_TOKEN(STK), .END_TOKEN(ETK)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .prim_data(prim_data), .prim_valid(prim_valid),
    .prim_ready(prim_ready), .frame_active(frame_active), .frame_done(frame_done),
    .drop_count(drop_count));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame flag, words gathered so far, primitives awaiting pickup.
  bit            m_active, m_after_prim, m_done;
  int            m_drop;
  logic [WW-1:0] cur[$];
  logic [PW-1:0] sb[$];
  bit            last_acc;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input bit clr_drop);
    m_active = 0; m_after_prim = 0; m_done = 0;
    cur.delete(); sb.delete();
    if (clr_drop) m_drop = 0;
  endtask

  task automatic step(input bit v, input logic [WW-1:0] d, input bit pr,
                      input bit r = 0, input bit f = 0);
    bit exp_rdy, pop;
    logic [PW-1:0] p;
    @(negedge clk);
    rst = r; flush = f; in_valid = v; in_data = d; prim_ready = pr;
    #1;
    exp_rdy = !r && !f && !(m_active && cur.size() == NW - 1 && sb.size() == OD);
    chk("in_ready", in_ready, exp_rdy);
    chk("prim_valid", prim_valid, sb.size() > 0);
    chk("prim_data", prim_data, (sb.size() > 0) ? sb[0] : '0);
    chk("frame_active", frame_active, m_active);
    chk("frame_done", frame_done, m_done);
    chk("drop_count", drop_count, m_drop[15:0]);
    last_acc = v && exp_rdy;
    pop = (sb.size() > 0) && pr;
    @(posedge clk);
    if (r) model_reset(1);
    else if (f) model_reset(0);
    else begin
      m_done = 0;
      if (pop) void'(sb.pop_front());
      if (last_acc) begin
        if (!m_active) begin
          if (d == STK) begin m_active = 1; m_after_prim = 0; end
          else if (m_drop < 16'hFFFF) m_drop++;
        end else if (m_after_prim && d == ETK) begin
          m_active = 0; m_after_prim = 0; m_done = 1;
        end else begin
          cur.push_back(d);
          m_after_prim = 0;
          if (cur.size() == NW) begin
            for (int k = 0; k < NW; k++) p[k*WW +: WW] = cur[k];
            sb.push_back(p);
            cur.delete();
            m_after_prim = 1;
          end
        end
      end
    end
  endtask

  // Offer a word until accepted, bounded so a stuck in_ready cannot hang the run.
  task automatic send(input logic [WW-1:0] d, input bit pr);
    for (int t = 0; t < 20; t++) begin
      step(1, d, pr);
      if (last_acc) break;
    end
    chk("send_accept", last_acc, 1'b1);
  endtask

  task automatic send_prim(input bit pr);
    for (int k = 0; k < NW; k++) send($urandom | 32'h100, pr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 1);
  endtask

  initial begin
    logic [WW-1:0] w;
    int sel;
    rst = 1; flush = 0; in_valid = 0; in_data = '0; prim_ready = 0;
    model_reset(1);
    repeat (2) @(posedge clk);
    step(0, '0, 0, 1, 0);

    // Single primitive with end token
    send(STK, 1); send_prim(1); send(ETK, 1); idle(3);
    // Leading garbage dropped, two back-to-back primitives
    send(32'd7, 1); send(32'd9, 1); send(STK, 1);
    send_prim(1); send_prim(1); send(ETK, 1); idle(3);
    chk("drop_after_garbage", drop_count, 16'd2);
    // Consumer stalled: two queue, third held at its last word
    send(STK, 0); send_prim(0); send_prim(0);
    for (int k = 0; k < NW - 1; k++) send($urandom | 32'h100, 0);
    w = $urandom | 32'h100;
    step(1, w, 0); step(1, w, 0);
    chk("held_last_word", last_acc, 1'b0);
    send(w, 1);
    send(ETK, 1); idle(4);
    // Reset mid-primitive, then a clean frame
    send(STK, 1); send(32'hD0, 1); send(32'hD1, 1); send(32'hD2, 1);
    step(0, '0, 1, 1, 0);
    idle(1);
    send(STK, 1); send_prim(1); send(ETK, 1); idle(3);
    // Flush mid-primitive with a queued primitive pending
    send(STK, 0); send_prim(0); send(32'hD0, 0); send(32'hD1, 0);
    step(1, 32'hD2, 1, 0, 1);
    idle(1);
    send(STK, 1); send_prim(1); send(ETK, 1); idle(3);
    // Start token as word 0 of a follow-on primitive
    send(STK, 1); send_prim(1); send(STK, 1);
    for (int k = 1; k < NW; k++) send($urandom | 32'h100, 1);
    send(ETK, 1); idle(3);

    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      w = (sel < 2) ? STK : (sel < 3) ? ETK : $urandom;
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
           $urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
